// File: rtl/apb_cmd_seq_pkg.sv
// Shared types and register map for the APB command sequencer.
package apb_cmd_seq_pkg;

  // Storage width of a queued command; the top narrows/widens to its own parameters.
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

  // Subtractor slave register map.
  localparam logic [CMD_ADDR_W-1:0] START_ADDR  = 32'h0;
  localparam logic [CMD_ADDR_W-1:0] SUB_ADDR    = 32'h4;
  localparam logic [CMD_ADDR_W-1:0] CTRL_ADDR   = 32'h8;
  localparam logic [CMD_ADDR_W-1:0] RESULT_ADDR = 32'hC;

endpackage

// File: rtl/apb_cmd_seq_fifo.sv
// Circular command buffer: DEPTH entries (power of 2), pointers wrap naturally.
// Head entry is presented combinationally so the sequencer can load it on pop.
module apb_cmd_fifo
  import apb_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  cmd_t                     i_din,
  output cmd_t                     o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Guard against overflow/underflow regardless of the caller.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // Storage array: no reset needed, contents are only read when count says valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_cmd_seq.sv
// Command sequencer feeding the request side of an APB master.
// Commands are queued in apb_cmd_fifo and issued one at a time; reads return
// through a valid/ready port, writes signal completion with wr_done.
// Optional macro APB_CMD_SEQ_TIMEOUT_EN: aborts an ACCESS phase after TIMEOUT
// cycles without PREADY and sets the sticky err flag.
module apb_cmd_seq
  import apb_cmd_seq_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              REQ_MASTER,
  output logic              PWRITE_MASTER,
  output logic [ADDR_W-1:0] PADDR_MASTER,
  output logic [DATA_W-1:0] PWDATA_MASTER,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA_MASTER,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              wr_done,
  output logic              busy,
  output logic              err
);

  state_t                r_state;
  logic                  r_req;
  logic                  r_pwrite;
  logic [ADDR_W-1:0]     r_paddr;
  logic [DATA_W-1:0]     r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_data;
  logic                  r_wr_done;

  cmd_t                  w_push_cmd;
  cmd_t                  w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_xfer_done;

  assign w_push_cmd.write = cmd_write;
  assign w_push_cmd.addr  = CMD_ADDR_W'(cmd_addr);
  assign w_push_cmd.wdata = CMD_DATA_W'(cmd_wdata);

  // cmd_ready comes from the registered count, so a pop never frees a slot early.
  assign cmd_ready   = ~w_full;
  assign w_push      = cmd_valid & cmd_ready;
  assign w_pop       = (r_state == IDLE) & ~w_empty;
  assign w_xfer_done = PSEL & PENABLE & PREADY;

  apb_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (PCLK),
    .i_rst_n (PRESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_cmd),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign REQ_MASTER    = r_req;
  assign PWRITE_MASTER = r_pwrite;
  assign PADDR_MASTER  = r_paddr;
  assign PWDATA_MASTER = r_pwdata;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign wr_done       = r_wr_done;
  assign busy          = (r_state != IDLE) | (w_count != '0);

`ifdef APB_CMD_SEQ_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] r_tcnt;
  logic           r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Transfer sequencing: one command in flight, request outputs only reload on IDLE->SETUP.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_wr_done   <= 1'b0;
`ifdef APB_CMD_SEQ_TIMEOUT_EN
      r_tcnt      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_req    <= 1'b1;
            r_pwrite <= w_head.write;
            r_paddr  <= ADDR_W'(w_head.addr);
            r_pwdata <= DATA_W'(w_head.wdata);
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          if (PSEL && !PENABLE) begin
            r_state <= ACCESS;
`ifdef APB_CMD_SEQ_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end
        end
        ACCESS: begin
          if (w_xfer_done) begin
            r_req <= 1'b0;
            if (r_pwrite) begin
              r_wr_done <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_rsp_data  <= PRDATA_MASTER;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end
          end
`ifdef APB_CMD_SEQ_TIMEOUT_EN
          // Slave never answered: drop the command silently and flag it.
          else if (r_tcnt == TCW'(TIMEOUT - 1)) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_cmd_seq.md
Name: apb_cmd_seq

Overview:
- Upstream command sequencer for the APB subtractor path: buffers software/host commands in a small FIFO and drives the APB master's request side (PWRITE_MASTER, PADDR_MASTER, PWDATA_MASTER).
- Issues one transfer at a time and tracks completion by observing PSEL/PENABLE/PREADY.
- Returns read data through a valid/ready response port.
- Lets a bench or CPU-side block queue a whole program (start value, subtract value, control, result read) without hand-timing transfers.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- DEPTH, 4, command FIFO entries; power of 2, >= 2.
- TIMEOUT, 16, cycles allowed in ACCESS before abort (optional feature only).

Ports:
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- REQ_MASTER  out  1  transfer request to APB master.
- PWRITE_MASTER  out  1  direction to master.
- PADDR_MASTER  out  ADDR_W  address to master.
- PWDATA_MASTER  out  DATA_W  write data to master.
- PSEL  in  1  observed from master.
- PENABLE  in  1  observed from master.
- PREADY  in  1  observed from slave.
- PRDATA_MASTER  in  DATA_W  read data from master.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_data  out  DATA_W  captured read data.
- wr_done  out  1  one-cycle pulse per completed write.
- busy  out  1  high whenever state is not IDLE or the FIFO is non-empty.
- err  out  1  sticky timeout flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset (PRESET=0, any time, including mid-transfer):
  - FIFO flushed, count=0, state IDLE.
  - Outputs all 0, except cmd_ready=1.
  - An in-flight transfer is abandoned without a response.
- FIFO:
  - Push when cmd_valid & cmd_ready.
  - Pop only in IDLE when the FIFO is non-empty.
  - Read/write pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
  - cmd_ready is derived from the registered count, so a push while full is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - A pushed command can be popped no earlier than the next cycle (no bypass).
- State machine (registered outputs):
  - IDLE:
    - FIFO non-empty -> pop head, load PWRITE/PADDR/PWDATA_MASTER, REQ_MASTER=1 -> SETUP.
    - Otherwise stay in IDLE.
  - SETUP: PSEL=1 & PENABLE=0 -> ACCESS. Otherwise hold all request outputs stable.
  - ACCESS: PSEL & PENABLE & PREADY -> REQ_MASTER=0, then:
    - Read: capture PRDATA_MASTER into rsp_data, rsp_valid=1 -> RESP.
    - Write: wr_done=1 for one cycle -> IDLE.
  - RESP:
    - Hold rsp_valid/rsp_data until rsp_ready.
    - On the handshake, rsp_valid=0 -> IDLE.
    - No new command issues while in RESP (strict ordering).
- Latency with PREADY tied 1:
  - Pop at edge N.
  - Completion seen at edge N+2 or N+3, depending on master phase.
  - Back-to-back write throughput: one command per 3 cycles minimum.
- Request outputs change only on an IDLE->SETUP edge; they are stable through SETUP and ACCESS.

Optional Feature:
- Macro: APB_CMD_SEQ_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in ACCESS.
  - Reaching TIMEOUT with PREADY still 0 -> REQ_MASTER=0, err=1 (sticky until reset).
  - The command is dropped: reads produce no response, writes produce no wr_done.
  - State -> IDLE.
- Undefined: ACCESS waits indefinitely; err tied 0; no counter logic.

Decomposition:
- Package apb_cmd_seq_pkg:
  - state enum {IDLE, SETUP, ACCESS, RESP}.
  - cmd_t struct {write, addr, wdata}.
  - Register address constants START_ADDR=0x0, SUB_ADDR=0x4, CTRL_ADDR=0x8, RESULT_ADDR=0xC.
- Sub-module apb_cmd_fifo: parameterised cmd_t circular buffer with push/pop/count/full/empty. The FSM lives in the top.

Test Plan:
- Queue W(0x0,15), W(0x4,3), W(0x8,1), W(0x8,1), R(0xC), with PREADY from the subtractor slave -> 4 wr_done pulses, then rsp_valid with rsp_data=9.
- Continue: W(0x4,19), W(0x8,1), R(0xC) -> rsp_data=0xFFFFFFF6.
- Hold rsp_ready=0, queue R(0x0) + 4 writes:
  - cmd_ready drops after the FIFO holds 4.
  - The 5th push is refused.
  - rsp_valid is held stable.
  - Releasing rsp_ready drains the remaining writes in order.
- Assert PRESET low while in ACCESS:
  - All outputs return to reset values asynchronously, cmd_ready=1, busy=0.
  - After release, a fresh R(0x4) returns the slave's current value.
- Push into a full FIFO in the same cycle as a pop -> push refused, count=DEPTH-1 next cycle.
- With APB_CMD_SEQ_TIMEOUT_EN, tie PREADY=0 and issue W(0x0,5):
  - err=1 exactly TIMEOUT cycles after entering ACCESS.
  - No wr_done; state returns to IDLE.
